// File: rtl/pix_rate_pkg.sv
// rtl/pix_rate_pkg.sv - shared types and defaults for the pixel rate controller
// Contents: rate_state_t (RUN/PEND/SETTLE), INC_W increment width,
// PKG_DEFAULT_INC and PKG_SETTLE_PULSES parameter defaults.
package pix_rate_pkg;

    localparam int INC_W = 16;

    localparam logic [INC_W-1:0] PKG_DEFAULT_INC   = 16'h8000;
    localparam int               PKG_SETTLE_PULSES = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_SETTLE = 2'd2
    } rate_state_t;

endpackage

// File: rtl/pix_phase_acc.sv
// rtl/pix_phase_acc.sv - phase accumulator producing the pixel clock-enable
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   inc  in   per-cycle phase increment
//   clr  in   clears phase and ce on the next edge (rate switch)
//   ce   out  registered carry-out of the 17-bit sum
module pix_phase_acc
    import pix_rate_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             clr,
    output logic             ce
);

    logic [INC_W-1:0] acc;
    logic [INC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            acc <= sum[INC_W-1:0];
            ce  <= sum[INC_W];
        end
    end

endmodule

// File: rtl/pix_rate_ctrl.sv
// rtl/pix_rate_ctrl.sv - pixel rate controller with frame-aligned rate switching
// Optional feature macro: PIX_RATE_CE_COUNT_EN (adds ce_count output).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/req_inc rate-change request (increment, pix rate = clk*inc/2^16)
//   req_ready         request can be accepted (RUN state)
//   frame_end         end-of-frame pulse; pending change is applied on it
//   pix_ce            registered pixel clock-enable
//   active_inc        increment currently applied
//   locked            rate stable and settled
//   err               one-cycle pulse on a rejected (zero) request
//   ce_count          pix_ce pulses in the last frame (PIX_RATE_CE_COUNT_EN only)
module pix_rate_ctrl
    import pix_rate_pkg::*;
#(
    parameter logic [INC_W-1:0] DEFAULT_INC   = PKG_DEFAULT_INC,
    parameter int               SETTLE_PULSES = PKG_SETTLE_PULSES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [INC_W-1:0] req_inc,
    output logic             req_ready,
    input  logic             frame_end,
    output logic             pix_ce,
    output logic [INC_W-1:0] active_inc,
    output logic             locked,
`ifdef PIX_RATE_CE_COUNT_EN
    output logic [15:0]      ce_count,
`endif
    output logic             err
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_PULSES - 1);

    rate_state_t      state, state_nxt;
    logic [INC_W-1:0] pending_inc;
    logic [3:0]       settle_cnt;
    logic             accept, reject, apply;

    pix_phase_acc u_acc (
        .clk (clk),
        .rst (rst),
        .inc (active_inc),
        .clr (apply),
        .ce  (pix_ce)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // frame_end only matters in PEND, so one arriving with the accept is ignored.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        locked    = 1'b1;
        accept    = 1'b0;
        reject    = 1'b0;
        apply     = 1'b0;
        case (state)
            ST_RUN: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_inc != '0) begin
                        accept    = 1'b1;
                        state_nxt = ST_PEND;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (frame_end) begin
                    apply     = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                locked = 1'b0;
                if (pix_ce && settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_inc  <= DEFAULT_INC;
            pending_inc <= '0;
            settle_cnt  <= '0;
            err         <= 1'b0;
        end else begin
            err <= reject;
            if (accept) pending_inc <= req_inc;
            if (apply) begin
                active_inc <= pending_inc;
                settle_cnt <= '0;
            end else if (state == ST_SETTLE && pix_ce) begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

`ifdef PIX_RATE_CE_COUNT_EN
    logic [15:0] ce_run;
    logic [16:0] ce_total;

    // A pulse on the frame_end cycle belongs to the frame being closed.
    assign ce_total = {1'b0, ce_run} + {16'd0, pix_ce};

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_run   <= '0;
            ce_count <= '0;
        end else if (frame_end) begin
            ce_count <= ce_total[16] ? 16'hFFFF : ce_total[15:0];
            ce_run   <= '0;
        end else if (pix_ce && ce_run != 16'hFFFF) begin
            ce_run <= ce_run + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pix_rate_ctrl.sv
// tb/tb_pix_rate_ctrl.sv - directed and randomized bench for pix_rate_ctrl
module tb_pix_rate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_inc;
    logic        req_ready;
    logic        frame_end;
    logic        pix_ce;
    logic [15:0] active_inc;
    logic        locked;
    logic        err;
`ifdef PIX_RATE_CE_COUNT_EN
    logic [15:0] ce_count;
`endif

    always #10 clk = ~clk;

    pix_rate_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_inc    (req_inc),
        .req_ready  (req_ready),
        .frame_end  (frame_end),
        .pix_ce     (pix_ce),
        .active_inc (active_inc),
        .locked     (locked),
`ifdef PIX_RATE_CE_COUNT_EN
        .ce_count   (ce_count),
`endif
        .err        (err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: phase as a plain integer, a pending request as -1/value,
    // and settling as "pulses still to see".
    int m_phase;
    int m_inc;
    int m_pending;
    int m_settle_left;
    bit m_ce;
    bit m_err;
    int m_ce_run;
    int m_ce_count;

    function automatic bit m_ready();
        return (m_pending < 0) && (m_settle_left == 0);
    endfunction

    task automatic model_edge();
        bit ready_before;
        bit ce_before;
        ready_before = m_ready();
        ce_before    = m_ce;
        if (rst) begin
            m_phase = 0; m_ce = 0; m_err = 0; m_inc = 'h8000;
            m_pending = -1; m_settle_left = 0; m_ce_run = 0; m_ce_count = 0;
            return;
        end
        if (frame_end) begin
            m_ce_count = m_ce_run + ce_before;
            if (m_ce_count > 'hFFFF) m_ce_count = 'hFFFF;
            m_ce_run = 0;
        end else if (ce_before && m_ce_run < 'hFFFF) begin
            m_ce_run++;
        end
        m_err = 0;
        if (m_settle_left > 0 && ce_before) m_settle_left--;
        if (m_pending >= 0 && frame_end) begin
            m_inc = m_pending;
            m_pending = -1;
            m_phase = 0;
            m_ce = 0;
            m_settle_left = 4;
        end else begin
            m_phase = m_phase + m_inc;
            m_ce = (m_phase >= 65536);
            m_phase = m_phase % 65536;
        end
        if (ready_before && req_valid) begin
            if (req_inc == 16'd0) m_err = 1;
            else m_pending = int'(req_inc);
        end
    endtask

    task automatic compare_all();
        chk("pix_ce", pix_ce, m_ce);
        chk("active_inc", active_inc, m_inc);
        chk("locked", locked, m_settle_left == 0);
        chk("req_ready", req_ready, m_ready());
        chk("err", err, m_err);
`ifdef PIX_RATE_CE_COUNT_EN
        chk("ce_count", ce_count, m_ce_count);
`endif
    endtask

    // Inputs are changed only while clk is low; outputs are sampled at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        req_valid = 0; req_inc = '0; frame_end = 0; rst = 0;
    endtask

    task automatic wait_locked(input int bound);
        int n;
        n = 0;
        while (!locked && n < bound) begin step(); n++; end
        chk("settle_timeout", locked, 1'b1);
    endtask

    initial begin
        int steps;
        bit hs;
        idle();
        rst = 1;
        @(negedge clk);
        step(); step();
        chk("rst_active_inc", active_inc, 16'h8000);
        chk("rst_locked", locked, 1'b1);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_pix_ce", pix_ce, 1'b0);

        // Divide-by-2 after reset.
        rst = 0;
        step(); chk("div2_edge1", pix_ce, 1'b0);
        step(); chk("div2_edge2", pix_ce, 1'b1);
        step(); chk("div2_edge3", pix_ce, 1'b0);
        step(); chk("div2_edge4", pix_ce, 1'b1);

        // Switch to 1/4 at a later frame_end.
        req_valid = 1; req_inc = 16'h4000;
        step(); idle();
        chk("pend_ready", req_ready, 1'b0);
        repeat (9) step();
        chk("pend_old_inc", active_inc, 16'h8000);
        frame_end = 1; step(); frame_end = 0;
        chk("switch_inc", active_inc, 16'h4000);
        chk("switch_unlocked", locked, 1'b0);
        steps = 0;
        while (!locked && steps < 40) begin step(); steps++; end
        chk("settle_cycles", steps, 17);

        // Zero increment is rejected.
        req_valid = 1; req_inc = 16'h0000;
        step(); idle();
        chk("zero_err", err, 1'b1);
        chk("zero_ready", req_ready, 1'b1);
        chk("zero_inc", active_inc, 16'h4000);
        step(); chk("zero_err_clear", err, 1'b0);

        // frame_end coincident with acceptance is ignored.
        req_valid = 1; req_inc = 16'h2000; frame_end = 1;
        step(); idle();
        repeat (5) step();
        chk("coinc_no_apply", active_inc, 16'h4000);
        frame_end = 1; step(); frame_end = 0;
        chk("coinc_apply", active_inc, 16'h2000);
        wait_locked(100);

        // Reset during SETTLE.
        req_valid = 1; req_inc = 16'h4000; step(); idle();
        frame_end = 1; step(); frame_end = 0;
        repeat (6) step();
        chk("pre_rst_locked", locked, 1'b0);
        rst = 1; step(); rst = 0;
        chk("rst_settle_inc", active_inc, 16'h8000);
        chk("rst_settle_locked", locked, 1'b1);
        chk("rst_settle_ready", req_ready, 1'b1);
        step(); chk("rst_settle_ce1", pix_ce, 1'b0);
        step(); chk("rst_settle_ce2", pix_ce, 1'b1);

`ifdef PIX_RATE_CE_COUNT_EN
        rst = 1; step(); rst = 0;
        for (int f = 0; f < 2; f++) begin
            repeat (99) step();
            frame_end = 1; step(); frame_end = 0;
        end
        chk("ce_count_50", ce_count, 16'd50);
`endif

        // Randomized traffic; the requester holds req_valid until accepted.
        for (int i = 0; i < 4000; i++) begin
            if (!req_valid && $urandom_range(0, 7) == 0) begin
                req_valid = 1;
                req_inc = ($urandom_range(0, 5) == 0) ? 16'd0
                                                      : 16'($urandom_range(16'h0800, 16'hFFFF));
            end
            frame_end = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 499) == 0);
            hs = req_valid && m_ready() && !rst;
            step();
            if (hs || rst) begin req_valid = 0; req_inc = '0; end
            frame_end = 0;
            rst = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
